// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared state, operand-select and K-select encodings for the Goldschmidt divider
package gs_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_D = 3'd1,
        S_INIT_N = 3'd2,
        S_ITER_D = 3'd3,
        S_ITER_N = 3'd4,
        S_DONE   = 3'd5
    } gs_state_t;

    localparam logic [1:0] SEL_D_INIT = 2'b00;
    localparam logic [1:0] SEL_N_INIT = 2'b01;
    localparam logic [1:0] SEL_D_ITER = 2'b10;
    localparam logic [1:0] SEL_N_ITER = 2'b11;

    localparam logic K_SEL_IA   = 1'b1;
    localparam logic K_SEL_COMP = 1'b0;

endpackage

// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - step sequencer driving the Goldschmidt divider datapath
module goldschmidt_ctrl
    import gs_pkg::*;
#(
    parameter int NUM_ITER = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    output logic             load_regN,
    output logic             load_regD,
    output logic [1:0]       sel_ND_mux,
    output logic             sel_K_mux,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    // The counter must be able to hold NUM_ITER without wrapping.
    if (NUM_ITER < 1 || NUM_ITER >= (1 << CNT_W)) begin : g_bad_num_iter
        $error("goldschmidt_ctrl: NUM_ITER must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    gs_state_t        state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    // State and iteration counter registers; reset forces IDLE without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state: hold freezes every state, including DONE; start only matters in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (!hold) begin
            unique case (state_q)
                S_IDLE:   if (start) state_d = S_INIT_D;
                S_INIT_D: state_d = S_INIT_N;
                S_INIT_N: begin
                    state_d = S_ITER_D;
                    iter_d  = ONE;
                end
                S_ITER_D: state_d = S_ITER_N;
                S_ITER_N: begin
                    if (iter_q < LAST_ITER) begin
                        state_d = S_ITER_D;
                        iter_d  = iter_q + ONE;
                    end else begin
                        state_d = S_DONE;
                        iter_d  = '0;
                    end
                end
                S_DONE:   state_d = start ? S_INIT_D : S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    iter_d  = '0;
                end
            endcase
        end
    end

    // Moore output decode; hold only masks the load enables so the selects stay stable.
    always_comb begin
        load_regN  = 1'b0;
        load_regD  = 1'b0;
        sel_ND_mux = SEL_D_INIT;
        sel_K_mux  = K_SEL_IA;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_INIT_D: begin
                load_regD = 1'b1;
                busy      = 1'b1;
            end
            S_INIT_N: begin
                load_regN  = 1'b1;
                sel_ND_mux = SEL_N_INIT;
                busy       = 1'b1;
            end
            S_ITER_D: begin
                load_regD  = 1'b1;
                sel_ND_mux = SEL_D_ITER;
                sel_K_mux  = K_SEL_COMP;
                busy       = 1'b1;
            end
            S_ITER_N: begin
                load_regN  = 1'b1;
                sel_ND_mux = SEL_N_ITER;
                sel_K_mux  = K_SEL_COMP;
                busy       = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        if (hold) begin
            load_regN = 1'b0;
            load_regD = 1'b0;
        end
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb/tb_goldschmidt_ctrl.sv - directed-vector bench for goldschmidt_ctrl
module tb_goldschmidt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       load_regN, load_regD, sel_K_mux, busy, done;
    logic [1:0] sel_ND_mux;
    logic [3:0] iter;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    goldschmidt_ctrl #(.NUM_ITER(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .load_regN(load_regN), .load_regD(load_regD), .sel_ND_mux(sel_ND_mux),
        .sel_K_mux(sel_K_mux), .busy(busy), .done(done), .iter(iter)
    );

    // {load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, iter}
    wire [10:0] obs = {load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, iter};

    localparam logic [10:0] IDLE_V = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0};
    localparam logic [10:0] DONE_V = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 4'd0};

    // Expected outputs c cycles after start was sampled (NUM_ITER=4): 1..10 busy, 11 done.
    function automatic logic [10:0] exp_step(input int c);
        logic [3:0] it;
        it = 4'((c - 1) / 2);
        if (c == 1)       return {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0};
        else if (c == 2)  return {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 4'd0};
        else if (c > 10)  return DONE_V;
        else if (c % 2)   return {1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, it};
        else              return {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, it};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_asserted: got %b want %b", obs, IDLE_V);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (obs !== IDLE_V) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, IDLE_V);
            end
        end
    endtask

    task automatic test_nominal(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            vectors++;
            if (obs !== exp_step(c)) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %b want %b", tag, c, obs, exp_step(c));
            end
            tick();
        end
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL %s after_done: got %b want %b", tag, obs, IDLE_V);
        end
    endtask

    task automatic test_hold();
        logic [10:0] want;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            hold = (c >= 5 && c <= 7);
            #1;
            if (c < 5)       want = exp_step(c);
            else if (c <= 7) want = exp_step(5) & 11'b00111111111;
            else             want = exp_step(c - 3);
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got %b want %b", c, obs, want);
            end
            tick();
        end
        hold = 1'b0;
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL hold after_done: got %b want %b", obs, IDLE_V);
        end
    endtask

    task automatic test_hold_idle_done();
        hold  = 1'b1;
        start = 1'b1;
        repeat (2) tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL hold_idle: got %b want %b", obs, IDLE_V);
        end
        hold = 1'b0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        hold = 1'b1;
        repeat (3) tick();
        vectors++;
        if (obs !== DONE_V) begin
            miscompares++;
            $display("FAIL hold_done_stretch: got %b want %b", obs, DONE_V);
        end
        hold = 1'b0;
        tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL hold_done_release: got %b want %b", obs, IDLE_V);
        end
    endtask

    task automatic test_back_to_back();
        int  busy_cnt = 0;
        bit  pulsed = 0;
        bit  seen_done = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            vectors++;
            if (obs !== exp_step(c)) begin
                miscompares++;
                $display("FAIL b2b_first cycle %0d: got %b want %b", c, obs, exp_step(c));
            end
            tick();
        end
        vectors++;
        if (obs !== exp_step(1)) begin
            miscompares++;
            $display("FAIL b2b_no_gap: got %b want %b", obs, exp_step(1));
        end
        start = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen_done = 1;
            end else begin
                start = (sel_ND_mux == 2'b11 && !pulsed);
                if (start) pulsed = 1;
                tick();
                start = 1'b0;
            end
        end
        vectors++;
        if (!seen_done || busy_cnt != 10) begin
            miscompares++;
            $display("FAIL b2b_busy_count: got %0d (done seen %0d) want 10 (done seen 1)",
                     busy_cnt, seen_done);
        end
        tick();
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL b2b_start_ignored: got %b want %b", obs, IDLE_V);
        end
    endtask

    task automatic test_reset_midop();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (obs !== exp_step(2)) begin
            miscompares++;
            $display("FAIL midrst_init_n: got %b want %b", obs, exp_step(2));
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want %b", obs, IDLE_V);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== IDLE_V) begin
                miscompares++;
                $display("FAIL midrst_hold[%0d]: got %b want %b", i, obs, IDLE_V);
            end
        end
        reset = 1'b1;
        tick();
        test_nominal("midrst_restart");
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_hold();
        test_hold_idle_done();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
- Control FSM for the Goldschmidt divider datapath. It generates the step sequence that the datapath bench currently drives by hand: sel_K_mux, load_regN, load_regD and sel_ND_mux.
- Sits beside `datapath` in the divider top level. One start request runs one complete division, and done pulses when the quotient in regN is final.

Parameters:
- NUM_ITER, 4, number of refinement iterations (K*D then K*N pairs) after the initial IA scaling. Legal range 1..15.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > NUM_ITER.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion forces the IDLE state immediately.
- start  input  1  request a division; sampled in IDLE or DONE.
- hold  input  1  stall. When 1, the FSM state and counter freeze and both loads are forced to 0.
- load_regN  output  1  datapath N-register load enable.
- load_regD  output  1  datapath D-register load enable.
- sel_ND_mux  output  2  datapath operand select: 00=D (initial), 01=N (initial), 10=D (iter), 11=N (iter).
- sel_K_mux  output  1  1=IA seed, 0=K from 2's-complement of D.
- busy  output  1  high from the first step through the last step.
- done  output  1  one-cycle pulse when the quotient is valid in regN.
- iter  output  CNT_W  index of the current refinement iteration, 1..NUM_ITER; 0 outside ITER states.

Behaviour:
- States: IDLE, INIT_D, INIT_N, ITER_D, ITER_N, DONE. Outputs are Moore, decoded from registered state and counter only; start and hold have no combinational path to any output except that hold gates the loads.
- Per-state outputs as {load_regN, load_regD, sel_ND_mux, sel_K_mux}:
  - IDLE: {0,0,00,1}
  - INIT_D: {0,1,00,1}
  - INIT_N: {1,0,01,1}
  - ITER_D: {0,1,10,0}
  - ITER_N: {1,0,11,0}
  - DONE: {0,0,00,1}
- busy=1 in INIT_*/ITER_*. done=1 only in DONE.
- Transitions:
  - IDLE with start=1 goes to INIT_D, then INIT_N, then ITER_D with iter=1.
  - ITER_D goes to ITER_N.
  - ITER_N with iter<NUM_ITER goes to ITER_D and increments iter.
  - ITER_N with iter==NUM_ITER goes to DONE.
  - DONE lasts exactly one cycle, then goes to INIT_D if start=1, else IDLE (back-to-back divisions are allowed).
- Latency: with hold=0, busy lasts exactly 2+2*NUM_ITER cycles. done asserts in the cycle after the last load_regN edge. Start to done is 3+2*NUM_ITER cycles (11 for default).
- hold=1 in any busy state: state and iter do not advance and both loads read 0. The sel outputs keep the current state's values. On release, the same step is re-issued with its load enable.
- hold=1 in IDLE or DONE: start is ignored, and DONE stays DONE (done held high) until hold drops. done is therefore one cycle per division only when hold=0.
- start while busy: ignored, with no queueing.
- Reset mid-operation: outputs immediately take IDLE values, iter=0, and no done pulse is produced. Datapath register contents are unspecified afterwards.
- Reset values: load_regN=0, load_regD=0, sel_ND_mux=00, sel_K_mux=1, busy=0, done=0, iter=0.
- iter counter: CNT_W bits, no wrap within the legal NUM_ITER range. An elaboration check fails if NUM_ITER<1 or NUM_ITER>=2^CNT_W.

Decomposition:
- Package gs_pkg holds:
  - the state enum gs_state_t (3 bits);
  - the sel_ND_mux encodings SEL_D_INIT, SEL_N_INIT, SEL_D_ITER, SEL_N_ITER;
  - K_SEL_IA and K_SEL_COMP.
- The package is shared with `datapath` and the top level.
- No sub-module: a single FSM plus counter. Top level `goldschmidt_div` instantiates goldschmidt_ctrl and datapath.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, release, start=0. All outputs stay at reset values for 5 cycles.
2. Nominal sequence: NUM_ITER=4, pulse start for 1 cycle. The next 10 cycles give {loadN,loadD,sel_ND,sel_K} = {0,1,00,1}, {1,0,01,1}, then 4 repetitions of {0,1,10,0},{1,0,11,0}, with iter reading 1,1,2,2,3,3,4,4 on the ITER cycles. done=1 on cycle 11 and busy=0 there.
3. Integration with datapath: IA=0x4000, N≈1.0461, D≈1.9831 in the datapath format. After done, result is within 1 ulp of the format's encoding of 0.52748, and D converges to 1.0 within 1 ulp.
4. Hold: assert hold for 3 cycles during the second ITER_D. The loads read 0 for those 3 cycles, the state and iter=2 are unchanged, and done arrives 3 cycles later (cycle 14).
5. Back-to-back and ignored start: start held high continuously gives DONE→INIT_D with no idle gap. A start pulse in the middle of ITER_N is ignored and the total count stays 10 busy cycles.
6. Reset mid-operation: drop reset during INIT_N. The outputs reach reset values without waiting for a clock edge, no done pulse appears, and a later start runs a full 10-step sequence.
